// File: rtl/list_pkg.sv
// Shared types and constants for the linked-list walk controller.
// A node is NodeWords words; the next pointer sits in the low bits of word 0.
package list_pkg;

  localparam int unsigned NodeWords  = 4;
  localparam int unsigned WordW      = 32;
  localparam int unsigned NextPtrLsb = 0;
  localparam int unsigned NullPtr    = 0;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWait,
    StEmit,
    StDone
  } walk_state_e;

  typedef logic [NodeWords-2:0][WordW-1:0] node_payload_t;

endpackage

// File: rtl/list_walk_ctrl_if.sv
// Request, memory-read, node-stream and completion signals of the list walker.
// master is the walker; slave is the requesters/memory/downstream side.
interface list_walk_ctrl_if #(
  parameter int unsigned DW   = 32,
  parameter int unsigned FS   = 4,
  parameter int unsigned NR   = 4,
  parameter int unsigned AW   = 32,
  parameter int unsigned MAXN = 256
) ();

  localparam int unsigned IDW = (NR > 1) ? $clog2(NR) : 1;
  localparam int unsigned CW  = $clog2(MAXN + 1);

  logic [NR-1:0]        req_valid;
  logic [NR*AW-1:0]     req_head;
  logic [NR-1:0]        req_ready;

  logic                 mem_ar_valid;
  logic [AW-1:0]        mem_ar_addr;
  logic                 mem_ar_ready;
  logic                 mem_r_valid;
  logic [FS*DW-1:0]     mem_r_data;
  logic                 mem_r_ready;

  logic                 node_valid;
  logic [(FS-1)*DW-1:0] node_data;
  logic [IDW-1:0]       node_id;
  logic                 node_last;
  logic                 node_ready;

  logic                 done_valid;
  logic [IDW-1:0]       done_id;
  logic [CW-1:0]        done_count;
  logic                 done_err;

  modport master (
    input  req_valid, req_head, mem_ar_ready, mem_r_valid, mem_r_data, node_ready,
    output req_ready, mem_ar_valid, mem_ar_addr, mem_r_ready,
    output node_valid, node_data, node_id, node_last,
    output done_valid, done_id, done_count, done_err
  );

  modport slave (
    output req_valid, req_head, mem_ar_ready, mem_r_valid, mem_r_data, node_ready,
    input  req_ready, mem_ar_valid, mem_ar_addr, mem_r_ready,
    input  node_valid, node_data, node_id, node_last,
    input  done_valid, done_id, done_count, done_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i (with wrap) wins.
// The rotating pointer is owned by the caller.
module rr_arbiter #(
  parameter int unsigned NR  = 4,
  parameter int unsigned IDW = (NR > 1) ? $clog2(NR) : 1
) (
  input  logic [NR-1:0]  req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [NR-1:0]  grant_o,
  output logic [IDW-1:0] grant_idx_o,
  output logic           any_o
);

  logic [IDW-1:0] idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    idx         = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = IDW'((32'(ptr_i) + k) % NR);
      if (!any_o && req_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/list_walk_ctrl.sv
// Shares one memory read port among NR requesters, walking one singly-linked list
// at a time and streaming each node's payload downstream.
module list_walk_ctrl
  import list_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned FS   = NodeWords,
  parameter int unsigned NR   = 4,
  parameter int unsigned AW   = 32,
  parameter int unsigned MAXN = 256,
  parameter int unsigned IDW  = (NR > 1) ? $clog2(NR) : 1,
  parameter int unsigned CW   = $clog2(MAXN + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  list_walk_ctrl_if.master bus,
  output logic             busy
);

  localparam int unsigned PW = (FS - 1) * DW;

  walk_state_e    state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [AW-1:0]  next_q, next_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  payload_q, payload_d;
  logic           err_q, err_d;

  logic [NR-1:0]  grant;
  logic [IDW-1:0] grant_idx;
  logic           grant_any;
  logic [AW-1:0]  head_sel;
  logic           at_guard;
  logic           next_null;

  rr_arbiter #(
    .NR  (NR),
    .IDW (IDW)
  ) u_arb (
    .req_i       (bus.req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  assign head_sel  = bus.req_head[32'(grant_idx) * AW +: AW];
  assign next_null = (next_q == AW'(NullPtr));
  // The node being emitted is the MAXN-th of this walk.
  assign at_guard  = (count_q == CW'(MAXN - 1));

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    addr_d    = addr_q;
    next_d    = next_q;
    count_d   = count_q;
    payload_d = payload_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          id_d     = grant_idx;
          addr_d   = head_sel;
          count_d  = '0;
          err_d    = 1'b0;
          rr_ptr_d = (grant_idx == IDW'(NR - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = (head_sel == AW'(NullPtr)) ? StDone : StAddr;
        end
      end
      StAddr: begin
        if (bus.mem_ar_ready) state_d = StWait;
      end
      StWait: begin
        if (bus.mem_r_valid) begin
          payload_d = bus.mem_r_data[FS*DW-1:DW];
          next_d    = bus.mem_r_data[NextPtrLsb +: AW];
          state_d   = StEmit;
        end
      end
      StEmit: begin
        if (bus.node_ready) begin
          count_d = count_q + 1'b1;
          if (next_null) begin
            err_d   = 1'b0;
            state_d = StDone;
          end else if (at_guard) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            addr_d  = next_q;
            state_d = StAddr;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      next_q    <= '0;
      count_q   <= '0;
      payload_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      next_q    <= next_d;
      count_q   <= count_d;
      payload_q <= payload_d;
      err_q     <= err_d;
    end
  end

  // Grant is combinational in IDLE but suppressed while reset is asserted.
  assign bus.req_ready    = (RESET && state_q == StIdle) ? grant : '0;

  assign bus.mem_ar_valid = (state_q == StAddr);
  assign bus.mem_ar_addr  = addr_q;
  assign bus.mem_r_ready  = (state_q == StWait);

  assign bus.node_valid   = (state_q == StEmit);
  assign bus.node_data    = payload_q;
  assign bus.node_id      = id_q;
  assign bus.node_last    = (state_q == StEmit) && (next_null || at_guard);

  assign bus.done_valid   = (state_q == StDone);
  assign bus.done_id      = id_q;
  assign bus.done_count   = count_q;
  assign bus.done_err     = err_q;

  assign busy             = (state_q != StIdle);

endmodule
